activation_sa: RTL and testbench
================================

Name: activation_sa

Overview:
- ReLU activation stage placed directly after the systolic-array accumulator.
- Takes one accumulated result per cycle, with its destination address and end-of-tile marker.
- Applies ReLU: negative values become 0, non-negative values pass unchanged.
- Forwards the result, address and last flag to the write-back/buffer stage with a fixed one-cycle register latency.

Parameters:
- DATA_W, 8, width of the accumulated/activated value (two's-complement signed).
- ADDR_W, 10, width of the result address carried alongside each value.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- acc_valid_i  input  1  accumulator result valid this cycle.
- acc_last_i  input  1  marks the final result of the current tile/matrix; meaningful only while acc_valid_i=1.
- acc_result_i  input  DATA_W  accumulated value, signed two's complement.
- acc_result_address_i  input  ADDR_W  destination address of acc_result_i.
- act_result_o  output  DATA_W  ReLU result.
- act_result_address_o  output  ADDR_W  address associated with act_result_o.
- act_last_o  output  1  last-of-tile marker aligned with act_result_o.
- act_valid_o  output  1  act_* outputs valid this cycle.

Behaviour:
- Reset (rst=1 at a rising clk edge): act_valid_o=0, act_last_o=0, act_result_o=0, act_result_address_o=0.
- Reset has priority over everything else, including a mid-stream transfer. The beat presented in the reset cycle is dropped; it is not output later.
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and stay until the next edge.
- Throughput: one result per cycle, no backpressure, no stall or ready signal. The block accepts every valid beat.
- ReLU arithmetic:
  - If acc_result_i[DATA_W-1]=1 (negative), act_result_o=0.
  - Otherwise act_result_o=acc_result_i.
  - No saturation or rescaling; output width equals input width.
  - The most negative value (8'h80) maps to 0.
- When acc_valid_i=1 at an edge, the registers load:
  - act_valid_o=1
  - act_result_o=ReLU(acc_result_i)
  - act_result_address_o=acc_result_address_i
  - act_last_o=acc_last_i
- When acc_valid_i=0 at an edge:
  - act_valid_o=0 and act_last_o=0.
  - act_result_o and act_result_address_o hold their previous values. Downstream must qualify them with act_valid_o.
- acc_last_i while acc_valid_i=0 is ignored, so act_last_o is never asserted without act_valid_o.
- Back-to-back tiles: a new tile may start on the cycle after the last beat, or after any number of idle cycles. No internal state carries over between tiles.
- Addresses pass through unchanged; no wrap or check is applied, and any ADDR_W value is legal.
- No FSM; the datapath is a single pipeline register stage.

Decomposition:
- Shared package (e.g. act_pkg):
  - DATA_W and ADDR_W default constants.
  - Typedef for the result beat: valid, last, address, data.
  - Zero constant used for the reset value.
- One natural sub-module, relu_unit: purely combinational, DATA_W-parameterised, sign-bit test and zero mux. Instantiated once inside activation_sa, which holds the output register stage.

Test Plan:
- Positive stream: after reset, valid beats data 1,2,3,4 at addresses 1..4 → one cycle later act_result_o=1,2,3,4, addresses 1..4, act_valid_o=1, act_last_o=0.
- Negative values: data 8'h85, 8'h86, 8'h80 at addresses 5,6,7 → act_result_o=0 for each, addresses 5,6,7 preserved. Data 8'h7F → 127.
- Tile end: 16-beat tile (addresses 1..16), acc_last_i=1 only on address 16 (data 8'h90) → act_last_o=1 only on the output beat with address 16 and result 0. Next cycle with acc_valid_i=0 → act_valid_o=0, act_last_o=0.
- Idle and bubble: acc_valid_i=0 with acc_last_i=1 and data 8'h05 → act_valid_o=0, act_last_o=0, act_result_o unchanged. Then a valid beat resumes with 1-cycle latency. Repeating the 16-beat tile a second time gives identical output.
- Reset mid-operation: rst=1 while a valid beat (data 9, address 9) is presented → next cycle all outputs are 0. The first valid beat after rst deasserts appears 1 cycle later.
- Width sweep: exhaustive DATA_W=8 input sweep -128..127 → output equals max(x,0). Repeat with DATA_W=16 and ADDR_W=12: 16'h8000→0, 16'h7FFF→32767.

Source files
------------

// File: rtl/activation_sa_pkg.sv
// Shared widths, result-beat type and reset constant for the ReLU stage.
package activation_sa_pkg;

    localparam int ACT_DATA_W = 8;
    localparam int ACT_ADDR_W = 10;

    // One result beat at the default widths, as handed to write-back.
    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [ACT_ADDR_W-1:0] addr;
        logic [ACT_DATA_W-1:0] data;
    } act_beat_t;

    localparam act_beat_t ACT_BEAT_ZERO = '0;

    localparam int ACT_BEAT_W = $bits(act_beat_t);

endpackage

// File: rtl/activation_sa_relu_unit.sv
// Combinational ReLU: negative two's-complement inputs clamp to zero.
module relu_unit #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Sign bit selects between zero and the unchanged value.
    always_comb begin
        dout = din;
        if (din[DATA_W-1]) dout = '0;
    end

endmodule

// File: rtl/activation_sa.sv
// ReLU stage after the systolic-array accumulator; single register stage,
// one beat per cycle, no backpressure.
module activation_sa
    import activation_sa_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int ADDR_W = ACT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid_i,
    input  logic              acc_last_i,
    input  logic [DATA_W-1:0] acc_result_i,
    input  logic [ADDR_W-1:0] acc_result_address_i,
    output logic [DATA_W-1:0] act_result_o,
    output logic [ADDR_W-1:0] act_result_address_o,
    output logic              act_last_o,
    output logic              act_valid_o
);

    // Same layout as act_beat_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             beat_q;
    logic [DATA_W-1:0] relu_d;

    relu_unit #(.DATA_W(DATA_W)) u_relu (
        .din  (acc_result_i),
        .dout (relu_d)
    );

    // Output register: flags follow the input every cycle, data/address
    // only load on valid beats and otherwise hold for the consumer to ignore.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q.valid <= acc_valid_i;
            beat_q.last  <= acc_valid_i & acc_last_i;
            if (acc_valid_i) begin
                beat_q.addr <= acc_result_address_i;
                beat_q.data <= relu_d;
            end
        end
    end

    assign act_valid_o          = beat_q.valid;
    assign act_last_o           = beat_q.last;
    assign act_result_address_o = beat_q.addr;
    assign act_result_o         = beat_q.data;

endmodule

// File: tb/tb_activation_sa.sv
// Directed bench for activation_sa at 8-bit and 16-bit data widths.
module tb_activation_sa;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v8, l8;
    logic [7:0]  d8;
    logic [9:0]  a8;
    logic [7:0]  r8;
    logic [9:0]  ra8;
    logic        lo8, vo8;

    logic        v16, l16;
    logic [15:0] d16;
    logic [11:0] a16;
    logic [15:0] r16;
    logic [11:0] ra16;
    logic        lo16, vo16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    activation_sa u_dut8 (
        .clk                  (clk),
        .rst                  (rst),
        .acc_valid_i          (v8),
        .acc_last_i           (l8),
        .acc_result_i         (d8),
        .acc_result_address_i (a8),
        .act_result_o         (r8),
        .act_result_address_o (ra8),
        .act_last_o           (lo8),
        .act_valid_o          (vo8)
    );

    activation_sa #(.DATA_W(16), .ADDR_W(12)) u_dut16 (
        .clk                  (clk),
        .rst                  (rst),
        .acc_valid_i          (v16),
        .acc_last_i           (l16),
        .acc_result_i         (d16),
        .acc_result_address_i (a16),
        .act_result_o         (r16),
        .act_result_address_o (ra16),
        .act_last_o           (lo16),
        .act_valid_o          (vo16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a beat for one edge, then scramble the inputs so the outputs
    // must come from the register rather than a combinational path.
    task automatic step8(input logic v, input logic l, input logic [7:0] d, input logic [9:0] a);
        v8 = v; l8 = l; d8 = d; a8 = a;
        @(posedge clk);
        #1;
        v8 = 1'b0; l8 = 1'b1; d8 = ~d; a8 = ~a;
        #1;
    endtask

    task automatic step16(input logic v, input logic l, input logic [15:0] d, input logic [11:0] a);
        v16 = v; l16 = l; d16 = d; a16 = a;
        @(posedge clk);
        #1;
        v16 = 1'b0; l16 = 1'b1; d16 = ~d; a16 = ~a;
        #1;
    endtask

    task automatic chk8(input string tag, input logic v, input logic l, input logic [7:0] r, input logic [9:0] a);
        chk({tag, ".valid"}, 32'(vo8), 32'(v));
        chk({tag, ".last"},  32'(lo8), 32'(l));
        chk({tag, ".data"},  32'(r8),  32'(r));
        chk({tag, ".addr"},  32'(ra8), 32'(a));
    endtask

    // 16-beat tile: data 3*i, last beat carries 8'h90 which clamps to 0.
    task automatic run_tile(input string tag);
        logic [7:0] dd;
        logic [7:0] ee;
        for (int i = 1; i <= 16; i++) begin
            dd = (i == 16) ? 8'h90 : 8'(3 * i);
            ee = (i == 16) ? 8'h00 : 8'(3 * i);
            step8(1'b1, i == 16, dd, 10'(i));
            chk8(tag, 1'b1, i == 16, ee, 10'(i));
        end
        step8(1'b0, 1'b0, 8'h00, 10'h0);
        chk({tag, ".idle_valid"}, 32'(vo8), 32'd0);
        chk({tag, ".idle_last"},  32'(lo8), 32'd0);
    endtask

    initial begin
        v8 = 0; l8 = 0; d8 = 0; a8 = 0;
        v16 = 0; l16 = 0; d16 = 0; a16 = 0;

        // Reset with a valid beat presented: it must be dropped.
        rst = 1'b1;
        step8(1'b1, 1'b1, 8'h44, 10'h123);
        chk8("reset", 1'b0, 1'b0, 8'h00, 10'h000);
        chk("reset16.data", 32'(r16), 32'd0);
        chk("reset16.valid", 32'(vo16), 32'd0);
        rst = 1'b0;

        // Positive stream.
        for (int i = 1; i <= 4; i++) begin
            step8(1'b1, 1'b0, 8'(i), 10'(i));
            chk8("pos", 1'b1, 1'b0, 8'(i), 10'(i));
        end

        // Negative values and the largest positive.
        step8(1'b1, 1'b0, 8'h85, 10'd5); chk8("neg85", 1'b1, 1'b0, 8'h00, 10'd5);
        step8(1'b1, 1'b0, 8'h86, 10'd6); chk8("neg86", 1'b1, 1'b0, 8'h00, 10'd6);
        step8(1'b1, 1'b0, 8'h80, 10'd7); chk8("neg80", 1'b1, 1'b0, 8'h00, 10'd7);
        step8(1'b1, 1'b0, 8'h7F, 10'd8); chk8("max7f", 1'b1, 1'b0, 8'd127, 10'd8);

        run_tile("tile1");

        // Idle with last asserted: flags drop, data/address hold.
        step8(1'b1, 1'b0, 8'h33, 10'h055); chk8("pre_idle", 1'b1, 1'b0, 8'h33, 10'h055);
        step8(1'b0, 1'b1, 8'h05, 10'h3FF); chk8("idle", 1'b0, 1'b0, 8'h33, 10'h055);
        step8(1'b0, 1'b0, 8'h06, 10'h001); chk8("idle2", 1'b0, 1'b0, 8'h33, 10'h055);
        step8(1'b1, 1'b0, 8'h11, 10'h2AA); chk8("resume", 1'b1, 1'b0, 8'h11, 10'h2AA);

        run_tile("tile2");

        // Reset mid-stream.
        step8(1'b1, 1'b0, 8'h21, 10'h021); chk8("pre_rst", 1'b1, 1'b0, 8'h21, 10'h021);
        rst = 1'b1;
        step8(1'b1, 1'b1, 8'd9, 10'd9);    chk8("mid_rst", 1'b0, 1'b0, 8'h00, 10'h000);
        rst = 1'b0;
        step8(1'b1, 1'b0, 8'd9, 10'd9);    chk8("post_rst", 1'b1, 1'b0, 8'd9, 10'd9);

        // Exhaustive 8-bit sweep.
        for (int x = -128; x < 128; x++) begin
            step8(1'b1, 1'b0, 8'(x), 10'(x + 128));
            chk("sweep.data", 32'(r8),  (x < 0) ? 32'd0 : 32'(x));
            chk("sweep.addr", 32'(ra8), 32'(x + 128));
        end

        // 16-bit instance.
        step16(1'b1, 1'b0, 16'h8000, 12'hFFF);
        chk("w16.8000", 32'(r16), 32'd0);
        chk("w16.addr_fff", 32'(ra16), 32'hFFF);
        chk("w16.valid", 32'(vo16), 32'd1);
        step16(1'b1, 1'b1, 16'h7FFF, 12'h800);
        chk("w16.7fff", 32'(r16), 32'd32767);
        chk("w16.addr_800", 32'(ra16), 32'h800);
        chk("w16.last", 32'(lo16), 32'd1);
        step16(1'b1, 1'b0, 16'hFFFF, 12'h001);
        chk("w16.ffff", 32'(r16), 32'd0);
        step16(1'b1, 1'b0, 16'h0100, 12'h002);
        chk("w16.0100", 32'(r16), 32'h100);
        step16(1'b0, 1'b1, 16'h1234, 12'h003);
        chk("w16.idle_valid", 32'(vo16), 32'd0);
        chk("w16.idle_last", 32'(lo16), 32'd0);
        chk("w16.idle_hold", 32'(r16), 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
